// File: rtl/regfile_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wport_arbiter_pkg
// Purpose  : Shared widths, arbiter state encoding and write-port record for
//            the register-file write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wport_arbiter_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // IDLE: buffer empty; DRAIN: head waiting for a free port;
    // FORCE: head has been denied long enough to steal the port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    // One register-file write at the default data width.
    typedef struct packed {
        logic                  wen;
        logic [REG_ADDR_W-1:0] dr;
        logic [XLEN-1:0]       data;
    } wport_t;

endpackage : regfile_wport_arbiter_pkg
`default_nettype wire

// File: rtl/regfile_wport_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wport_fifo
// Purpose  : Small synchronous FIFO buffering long-latency results until the
//            register-file write port is granted to them.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wport_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int WIDTH = 69,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int               c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Overflow and underflow requests are ignored rather than corrupting state.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule : regfile_wport_fifo
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wport_arbiter
// Purpose  : Shares the register-file write port between the in-order
//            writeback stage (default priority) and buffered long-latency
//            results, forcing a one-cycle writeback stall on starvation.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::REG_ADDR_W,
           regfile_wport_arbiter_pkg::arb_state_t,
           regfile_wport_arbiter_pkg::IDLE,
           regfile_wport_arbiter_pkg::DRAIN,
           regfile_wport_arbiter_pkg::FORCE;
#(
    parameter int XLEN         = regfile_wport_arbiter_pkg::XLEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WB_REG_WEN,
    input  logic [REG_ADDR_W-1:0] WB_DR,
    input  logic [XLEN-1:0]       WB_DATA,
    input  logic                  LL_V,
    input  logic [REG_ADDR_W-1:0] LL_DR,
    input  logic [XLEN-1:0]       LL_DATA,
    output logic                  LL_READY,
    output logic                  OUT_DE_REG_WEN,
    output logic [REG_ADDR_W-1:0] OUT_DE_DR,
    output logic [XLEN-1:0]       OUT_DE_Data,
    output logic                  WB_STALL,
    output logic                  LL_PENDING
);

    localparam int c_ENTRY_W  = REG_ADDR_W + XLEN;
    localparam int c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE    = c_CNT_W'(1);

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    logic [c_STARVE_W-1:0]   r_starve;
    logic [c_STARVE_W-1:0]   w_starve_next;

    logic                    w_wb_req;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_bypass;
    logic                    w_stall;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [c_CNT_W-1:0]      w_fifo_count;
    logic [c_CNT_W-1:0]      w_cnt_next;
    logic [c_ENTRY_W-1:0]    w_head;
    logic [REG_ADDR_W-1:0]   w_head_dr;
    logic [XLEN-1:0]         w_head_data;

    logic                    w_port_wen;
    logic [REG_ADDR_W-1:0]   w_port_dr;
    logic [XLEN-1:0]         w_port_data;

    // Writes to x0 are not real writes and never claim the port.
    assign w_wb_req    = WB_REG_WEN && (WB_DR != '0);
    assign w_head_dr   = w_head[c_ENTRY_W-1 -: REG_ADDR_W];
    assign w_head_data = w_head[XLEN-1:0];

    regfile_wport_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RESET),
        .i_push      (w_push),
        .i_push_data ({LL_DR, LL_DATA}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Arbiter state and starvation counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
        end
    end

    // Port grant, buffer push/pop and next state from post-edge occupancy.
    always_comb begin
        w_port_wen    = 1'b0;
        w_port_dr     = '0;
        w_port_data   = '0;
        w_stall       = 1'b0;
        w_pop         = 1'b0;
        w_bypass      = 1'b0;
        w_starve_next = r_starve;
        w_state_next  = r_state;

        case (r_state)
            IDLE: begin
                if (w_wb_req) begin
                    w_port_wen  = 1'b1;
                    w_port_dr   = WB_DR;
                    w_port_data = WB_DATA;
                end else if (LL_V) begin
                    // Free port and empty buffer: write straight through.
                    w_bypass    = 1'b1;
                    w_port_wen  = (LL_DR != '0);
                    w_port_dr   = LL_DR;
                    w_port_data = LL_DATA;
                end
            end
            DRAIN: begin
                if (w_wb_req) begin
                    w_port_wen  = 1'b1;
                    w_port_dr   = WB_DR;
                    w_port_data = WB_DATA;
                    if (r_starve != c_STARVE_MAX)
                        w_starve_next = r_starve + c_STARVE_ONE;
                end else begin
                    w_pop         = 1'b1;
                    w_port_wen    = (w_head_dr != '0);
                    w_port_dr     = w_head_dr;
                    w_port_data   = w_head_data;
                    w_starve_next = '0;
                end
            end
            FORCE: begin
                w_stall       = 1'b1;
                w_pop         = 1'b1;
                w_port_wen    = (w_head_dr != '0);
                w_port_dr     = w_head_dr;
                w_port_data   = w_head_data;
                w_starve_next = '0;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_push     = LL_V && !w_fifo_full && !w_bypass;
        w_cnt_next = w_fifo_count
                   + (w_push ? c_CNT_ONE : '0)
                   - (w_pop  ? c_CNT_ONE : '0);

        if (w_cnt_next == '0)
            w_state_next = IDLE;
        else if (w_starve_next == c_STARVE_MAX)
            w_state_next = FORCE;
        else
            w_state_next = DRAIN;
    end

    // All outputs are held low while reset is asserted.
    assign LL_READY       = !w_fifo_full && !RESET;
    assign LL_PENDING     = !w_fifo_empty && !RESET;
    assign WB_STALL       = w_stall && !RESET;
    assign OUT_DE_REG_WEN = w_port_wen && !RESET;
    assign OUT_DE_DR      = RESET ? '0 : w_port_dr;
    assign OUT_DE_Data    = RESET ? '0 : w_port_data;

endmodule : regfile_wport_arbiter
`default_nettype wire
